// File: rtl/mcycle_alu_if.sv
// Request/response bus of the multi-cycle ALU: operand request channel and result channel,
// each with its own valid/ready handshake.
interface mcycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, op1, op2, alu_op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op1, op2, alu_op, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/mcycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus optional bit-serial MUL/MULHU/DIVU/REMU.
// Define ALU_MULDIV_EN to build the iterative multiply/divide datapath and its EXEC state.
module mcycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  mcycle_alu_if.slave  bus
);

  localparam logic [3:0] ALUOP_AND   = 4'd0;
  localparam logic [3:0] ALUOP_OR    = 4'd1;
  localparam logic [3:0] ALUOP_XOR   = 4'd2;
  localparam logic [3:0] ALUOP_ADD   = 4'd3;
  localparam logic [3:0] ALUOP_SUB   = 4'd4;
  localparam logic [3:0] ALUOP_SLT   = 4'd5;
  localparam logic [3:0] ALUOP_SLL   = 4'd6;
  localparam logic [3:0] ALUOP_SRL   = 4'd7;
  localparam logic [3:0] ALUOP_SRA   = 4'd8;
  localparam logic [3:0] ALUOP_SLTU  = 4'd9;
  localparam logic [3:0] ALUOP_MUL   = 4'd10;
  localparam logic [3:0] ALUOP_MULHU = 4'd11;
  localparam logic [3:0] ALUOP_DIVU  = 4'd12;
  localparam logic [3:0] ALUOP_REMU  = 4'd13;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_is_iter;
  logic [SHW-1:0]   w_shamt;

  assign w_shamt = bus.op2[SHW-1:0];

  always_comb begin
    w_alu_res = '0;
    w_is_iter = 1'b0;
    case (bus.alu_op)
      ALUOP_AND:  w_alu_res = bus.op1 & bus.op2;
      ALUOP_OR:   w_alu_res = bus.op1 | bus.op2;
      ALUOP_XOR:  w_alu_res = bus.op1 ^ bus.op2;
      ALUOP_ADD:  w_alu_res = bus.op1 + bus.op2;
      ALUOP_SUB:  w_alu_res = bus.op1 - bus.op2;
      ALUOP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
      ALUOP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.op1 < bus.op2)};
      ALUOP_SLL:  w_alu_res = bus.op1 << w_shamt;
      ALUOP_SRL:  w_alu_res = bus.op1 >> w_shamt;
      ALUOP_SRA:  w_alu_res = $unsigned($signed(bus.op1) >>> w_shamt);
`ifdef ALU_MULDIV_EN
      ALUOP_MUL, ALUOP_MULHU, ALUOP_DIVU, ALUOP_REMU: w_is_iter = 1'b1;
`else
      // Without the mul/div datapath these are treated exactly like unknown opcodes.
      ALUOP_MUL, ALUOP_MULHU, ALUOP_DIVU, ALUOP_REMU: w_alu_res = '0;
`endif
      default:    w_alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  logic [SHW:0]     r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opa;

  logic             w_acc_mul;
  logic             w_iter_mul;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic [WIDTH-1:0] w_iter_res;

  assign w_acc_mul  = (bus.alu_op == ALUOP_MUL) || (bus.alu_op == ALUOP_MULHU);
  assign w_iter_mul = (r_op == ALUOP_MUL) || (r_op == ALUOP_MULHU);

  // Multiply: {hi,lo} holds partial product and remaining multiplier bits, shifted right each step.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
  // Restoring divide: hi is the remainder, lo shifts dividend bits out and quotient bits in.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opa});
  assign w_div_diff  = w_div_shift - {1'b0, r_opa};

  always_comb begin
    if (w_iter_mul) begin
      w_hi_next = w_mul_sum[WIDTH:1];
      w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_next = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], w_div_ge};
    end
  end

  always_comb begin
    w_iter_res = '0;
    case (r_op)
      ALUOP_MUL:   w_iter_res = r_lo;
      ALUOP_MULHU: w_iter_res = r_hi;
      ALUOP_DIVU:  w_iter_res = r_lo;
      ALUOP_REMU:  w_iter_res = r_hi;
      default:     w_iter_res = '0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
`ifdef ALU_MULDIV_EN
      r_cnt       <= '0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opa       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
`ifdef ALU_MULDIV_EN
            r_cnt <= '0;
            if (w_is_iter) begin
              r_op    <= bus.alu_op;
              r_hi    <= '0;
              r_lo    <= w_acc_mul ? bus.op2 : bus.op1;
              r_opa   <= w_acc_mul ? bus.op1 : bus.op2;
              r_state <= S_EXEC;
            end else begin
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
`else
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`endif
          end
        end
`ifdef ALU_MULDIV_EN
        S_EXEC: begin
          // WIDTH steps run at counts 0..WIDTH-1; the extra cycle at WIDTH publishes the result.
          if (r_cnt == CNT_LAST) begin
            r_result    <= w_iter_res;
            r_zero      <= (w_iter_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;

endmodule
